// File: rtl/mem_cycle_sequencer.sv
// Memory cycle sequencer: owns the shared 8-bit data bus and steps each
// instruction through fetch-low, fetch-high, execute and an optional
// load/store data cycle, producing memory strobes and latch enables.
module mem_cycle_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              dec_load,
    input  logic              dec_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe_,
    output logic              mem_we_,
    output logic              op_lo_en,
    output logic              op_hi_en,
    output logic              pc_step,
    output logic              exec_en,
    output logic              ld_data_en,
    output logic              st_data_oe_,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        EXEC     = 3'd3,
        LOAD     = 3'd4,
        STORE    = 3'd5
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_cycle;
    logic       we_low_d;

    assign last_cycle = (cnt_q == LAST_CNT);

    // Write strobe is low inside the store window, leaving setup and hold cycles
    // high; with a single wait cycle there is no room for a separate hold cycle.
    assign we_low_d = (state_d == STORE) && (cnt_d >= 3'd1) &&
                      ((cnt_d < LAST_CNT) || (WAIT_CYCLES == 1));

    // Execute-cycle write-back depends on the freshly latched opcode, so it is
    // decoded combinationally from the current state rather than registered.
    assign exec_en = (state_q == EXEC) && !dec_load && !dec_store;

    // Next-state and wait-counter logic; the counter clears on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH_LO;
            end
            FETCH_LO: begin
                if (last_cycle) state_d = FETCH_HI;
                else            cnt_d   = cnt_q + 3'd1;
            end
            FETCH_HI: begin
                if (last_cycle) state_d = EXEC;
                else            cnt_d   = cnt_q + 3'd1;
            end
            EXEC: begin
                if (dec_load)       state_d = LOAD;
                else if (dec_store) state_d = STORE;
                else if (run)       state_d = FETCH_LO;
                else                state_d = IDLE;
            end
            LOAD, STORE: begin
                if (last_cycle) state_d = run ? FETCH_LO : IDLE;
                else            cnt_d   = cnt_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs computed from the upcoming state so strobes are glitch-free
    // and aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_oe_     <= 1'b1;
            mem_we_     <= 1'b1;
            st_data_oe_ <= 1'b1;
            op_lo_en    <= 1'b0;
            op_hi_en    <= 1'b0;
            pc_step     <= 1'b0;
            ld_data_en  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                case (state_d)
                    FETCH_LO:    mem_addr <= pc;
                    FETCH_HI:    mem_addr <= pc + ADDR_W'(1);
                    EXEC:        mem_addr <= pc;
                    LOAD, STORE: mem_addr <= ls_addr;
                    default:     mem_addr <= mem_addr;
                endcase
            end
            mem_oe_     <= !((state_d == FETCH_LO) || (state_d == FETCH_HI) ||
                             (state_d == LOAD));
            mem_we_     <= !we_low_d;
            st_data_oe_ <= !(state_d == STORE);
            op_lo_en    <= (state_d == FETCH_LO) && (cnt_d == LAST_CNT);
            op_hi_en    <= (state_d == FETCH_HI) && (cnt_d == LAST_CNT);
            pc_step     <= ((state_d == FETCH_LO) || (state_d == FETCH_HI)) &&
                           (cnt_d == LAST_CNT);
            ld_data_en  <= (state_d == LOAD) && (cnt_d == LAST_CNT);
            busy        <= (state_d != IDLE);
        end
    end

    // A decoded op that is both a load and a store is a decoder bug.
    assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == EXEC) && dec_load && dec_store));

    // Bus contention guard between read and write strobes.
    assert property (@(posedge clk) disable iff (!rst_n) !(!mem_oe_ && !mem_we_));

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Testbench for mem_cycle_sequencer: cycle-by-cycle vector table for a plain,
// load and store instruction, plus hand sequences for reset mid-store, run
// dropped mid-instruction and a long random instruction stream.
module tb_mem_cycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] pc;
    logic [15:0] ls_addr;
    logic        dec_load;
    logic        dec_store;
    logic [15:0] mem_addr;
    logic        mem_oe_;
    logic        mem_we_;
    logic        op_lo_en;
    logic        op_hi_en;
    logic        pc_step;
    logic        exec_en;
    logic        ld_data_en;
    logic        st_data_oe_;
    logic        busy;

    logic [7:0]  bus;
    logic [7:0]  ld_reg;
    logic [24:0] out_vec;
    int          check_count;
    int          pass_count;
    int          overlap_count;

    localparam logic [24:0] RESET_VEC = {16'h0000, 9'b111_000_000};

    typedef struct {
        logic        run;
        logic        dec_load;
        logic        dec_store;
        logic [15:0] ls_addr;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];

    mem_cycle_sequencer #(.ADDR_W(16), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .pc          (pc),
        .ls_addr     (ls_addr),
        .dec_load    (dec_load),
        .dec_store   (dec_store),
        .mem_addr    (mem_addr),
        .mem_oe_     (mem_oe_),
        .mem_we_     (mem_we_),
        .op_lo_en    (op_lo_en),
        .op_hi_en    (op_hi_en),
        .pc_step     (pc_step),
        .exec_en     (exec_en),
        .ld_data_en  (ld_data_en),
        .st_data_oe_ (st_data_oe_),
        .busy        (busy)
    );

    assign out_vec = {mem_addr, mem_oe_, mem_we_, st_data_oe_, op_lo_en, op_hi_en,
                      pc_step, exec_en, ld_data_en, busy};

    // Memory returns 0xA5 at the load address, floating-high elsewhere.
    assign bus = (!mem_oe_ && mem_addr == 16'h8042) ? 8'hA5 : 8'hFF;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter and load-data register as the mainboard would hold them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= 16'h0010;
            ld_reg <= 8'h00;
        end else begin
            if (pc_step)    pc     <= pc + 16'h0001;
            if (ld_data_en) ld_reg <= bus;
        end
    end

    // Strobe contention monitor.
    always @(negedge clk) begin
        if (rst_n && !mem_oe_ && !mem_we_) overlap_count++;
    end

    function automatic vec_t mk(input logic r, input logic dl, input logic ds,
                                input logic [15:0] ls, input logic [15:0] addr,
                                input logic [8:0] flags);
        vec_t v;
        v.run       = r;
        v.dec_load  = dl;
        v.dec_store = ds;
        v.ls_addr   = ls;
        v.exp       = {addr, flags};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        run       = v.run;
        dec_load  = v.dec_load;
        dec_store = v.dec_store;
        ls_addr   = v.ls_addr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        run       = 1'b0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        ls_addr   = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // flags = {oe_, we_, st_oe_, op_lo, op_hi, pc_step, exec_en, ld_en, busy}
    task automatic fillTable();
        vecs.delete();
        vecs.push_back(mk(1,0,0,16'h8042,16'h0000,9'b111_000_000)); // c0 idle
        vecs.push_back(mk(1,0,0,16'h8042,16'h0010,9'b011_000_001)); // c1 fetch lo
        vecs.push_back(mk(1,0,0,16'h8042,16'h0010,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0010,9'b011_101_001)); // c3 op_lo
        vecs.push_back(mk(1,0,0,16'h8042,16'h0011,9'b011_000_001)); // c4 fetch hi
        vecs.push_back(mk(1,0,0,16'h8042,16'h0011,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0011,9'b011_011_001)); // c6 op_hi
        vecs.push_back(mk(1,0,0,16'h8042,16'h0011,9'b111_000_101)); // c7 exec
        vecs.push_back(mk(1,0,0,16'h8042,16'h0012,9'b011_000_001)); // c8 fetch lo
        vecs.push_back(mk(1,0,0,16'h8042,16'h0012,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0012,9'b011_101_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0013,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0013,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0013,9'b011_011_001));
        vecs.push_back(mk(1,1,0,16'h8042,16'h0013,9'b111_000_001)); // c14 exec load
        vecs.push_back(mk(1,0,0,16'h8042,16'h8042,9'b011_000_001)); // c15 load
        vecs.push_back(mk(1,0,0,16'h8042,16'h8042,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h8042,9'b011_000_011)); // c17 ld_en
        vecs.push_back(mk(1,0,0,16'h8042,16'h0014,9'b011_000_001)); // c18 fetch lo
        vecs.push_back(mk(1,0,0,16'h8042,16'h0014,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0014,9'b011_101_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0015,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0015,9'b011_000_001));
        vecs.push_back(mk(1,0,0,16'h8042,16'h0015,9'b011_011_001));
        vecs.push_back(mk(1,0,1,16'h1234,16'h0015,9'b111_000_001)); // c24 exec store
        vecs.push_back(mk(1,0,0,16'h1234,16'h1234,9'b110_000_001)); // c25 setup
        vecs.push_back(mk(0,0,0,16'h1234,16'h1234,9'b100_000_001)); // c26 write
        vecs.push_back(mk(0,0,0,16'h1234,16'h1234,9'b110_000_001)); // c27 hold
        vecs.push_back(mk(0,0,0,16'h1234,16'h1234,9'b111_000_000)); // c28 idle
        vecs.push_back(mk(0,0,0,16'h1234,16'h1234,9'b111_000_000));
    endtask

    initial begin
        check_count   = 0;
        pass_count    = 0;
        overlap_count = 0;

        // Vector table: plain op, load, store, then stop.
        doReset();
        checkOutput("reset_state", {7'd0, out_vec}, {7'd0, RESET_VEC});
        fillTable();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec_c%0d", i), {7'd0, out_vec}, {7'd0, vecs[i].exp});
            @(posedge clk);
            #1;
        end
        checkOutput("load_data", {24'd0, ld_reg}, 32'h0000_00A5);

        // Reset asserted on write cycle of a store.
        begin
            logic found;
            doReset();
            run       = 1'b1;
            dec_store = 1'b1;
            ls_addr   = 16'h1234;
            found     = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                if (!st_data_oe_) found = 1'b1;
            end
            checkOutput("store_reached", {31'd0, found}, 32'd1);
            @(negedge clk);
            checkOutput("store_we_cycle1", {31'd0, mem_we_}, 32'd0);
            #2 rst_n = 1'b0;
            #1;
            checkOutput("reset_mid_store", {7'd0, out_vec}, {7'd0, RESET_VEC});
        end

        // Run dropped during the high-byte fetch.
        begin
            logic found;
            doReset();
            run   = 1'b1;
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                if (op_lo_en) found = 1'b1;
            end
            @(posedge clk);
            #1;
            run = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk);
                if (exec_en) found = 1'b1;
            end
            checkOutput("rundrop_exec", {31'd0, found}, 32'd1);
            @(negedge clk);
            checkOutput("rundrop_idle", {30'd0, busy, mem_oe_}, 32'b01);
            @(negedge clk);
            checkOutput("rundrop_stays_idle", {31'd0, busy}, 32'd0);
            run = 1'b1;
            @(negedge clk);
            checkOutput("restart_fetch", {14'd0, busy, mem_oe_, mem_addr},
                        {14'd0, 2'b10, 16'h0012});
        end

        // Long random instruction stream.
        begin
            int ops;
            int sel;
            doReset();
            overlap_count = 0;
            ops = 0;
            run = 1'b1;
            for (int c = 0; c < 20000 && ops < 1000; c++) begin
                sel       = $urandom_range(0, 2);
                dec_load  = (sel == 1);
                dec_store = (sel == 2);
                @(negedge clk);
                if (op_hi_en) ops++;
                @(posedge clk);
                #1;
            end
            checkOutput("random_ops", ops, 1000);
            run = 1'b0;
            for (int c = 0; c < 20 && busy; c++) @(negedge clk);
            checkOutput("random_idle", {31'd0, busy}, 32'd0);
            checkOutput("random_pc", {16'd0, pc}, {16'd0, 16'h07E0});
            checkOutput("oe_we_overlap", overlap_count, 0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
